aibcr3_rstseq_fsm: RTL and testbench
====================================

# aibcr3_rstseq_fsm

Reset release sequencer that consumes the output of the 2-flop asynchronous reset/data synchronizer in the AIB channel reset path. Takes the already-synchronized enable and releases two downstream reset domains in a fixed order with programmable spacing: A (e.g. datapath flops) first, then B (e.g. adapter/FIFO pointers). Optionally waits for an acknowledge from domain B before flagging completion. Any drop of the enable re-asserts both resets immediately, on the next clock edge.

## Interface
Parameters:
- CNT_W, 8, width of the internal delay counter.
- DLY_A, 4, cycles from accepted enable to RSTN_A release; legal range 1 .. 2^CNT_W-1.
- DLY_B, 8, cycles from RSTN_A release to RSTN_B release; legal range 1 .. 2^CNT_W-1.

Ports:
- CK  input  1  clock, same domain as the upstream synchronizer.
- CLR_N  input  1  reset; asynchronous, active-low.
- EN_SYNC  input  1  synchronized sequence enable, driven by the upstream synchronizer Q; level-sensitive.
- ACK_B  input  1  domain-B ready acknowledge, synchronous to CK; ignored unless AIBCR3_RSTSEQ_ACK_EN.
- RSTN_A  output  1  registered active-low reset for domain A.
- RSTN_B  output  1  registered active-low reset for domain B.
- DONE  output  1  registered; sequence complete.
- BUSY  output  1  registered; high in any state other than IDLE and DONE.

## Operation
- States: IDLE, CNT_A, CNT_B, WAIT_ACK (present only with the macro), DONE. Encoding is free; the counter is CNT_W bits.
- Asserting CLR_N low forces, asynchronously: state IDLE, cnt=0, RSTN_A=0, RSTN_B=0, DONE=0, BUSY=0.
- IDLE: if EN_SYNC=1, go to CNT_A with cnt=1 and BUSY=1.
- CNT_A: if cnt==DLY_A, set RSTN_A=1, cnt=1, go to CNT_B. Otherwise cnt+1.
- CNT_B: if cnt==DLY_B, set RSTN_B=1.
  - Without the macro: DONE=1, BUSY=0, go to DONE.
  - With the macro: go to WAIT_ACK.
  - Otherwise cnt+1.
- WAIT_ACK: if ACK_B=1, set DONE=1, BUSY=0, go to DONE. There is no timeout; the sequencer waits indefinitely.
- DONE: hold. RSTN_A, RSTN_B and DONE stay 1. ACK_B is ignored.
- Abort: EN_SYNC=0 is sampled in any state other than IDLE.
  - Next edge: RSTN_A=RSTN_B=DONE=BUSY=0, cnt=0, state IDLE.
  - Abort has priority over every transition on the same edge, including a counter match or ACK_B=1.
- Restart: after an abort or a return to IDLE, EN_SYNC=1 restarts the full sequence from cnt=1. Partial progress is never resumed.
- The counter never wraps: the legal ranges for DLY_A and DLY_B guarantee a match before overflow. DLY_A and DLY_B are checked at elaboration; an illegal value is a fatal error.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Edge numbering: edge k is the first edge at which EN_SYNC=1 is sampled in IDLE.
- BUSY rises after edge k.
- RSTN_A rises after edge k+DLY_A.
- RSTN_B rises after edge k+DLY_A+DLY_B.
- Without the macro: DONE rises on the same edge as RSTN_B, and BUSY falls on that edge.
- With the macro: DONE rises after the first edge j > k+DLY_A+DLY_B at which ACK_B=1. Earliest case: j = k+DLY_A+DLY_B+1.
- Abort latency: 1 edge from EN_SYNC sampled low to all outputs low.
- End-to-end from a raw async enable: add the 2 upstream synchronizer cycles. Those 2 cycles are not counted inside this block.
- Minimum EN_SYNC low pulse to force a restart: 1 CK cycle.

## Configuration
- AIBCR3_RSTSEQ_ACK_EN, defined:
  - WAIT_ACK state is present.
  - DONE is gated by ACK_B, as described above.
- AIBCR3_RSTSEQ_ACK_EN, undefined:
  - WAIT_ACK logic is not compiled.
  - ACK_B is left unconnected internally.
  - DONE asserts on the same edge as RSTN_B.

## Test plan
- Reset: CLR_N=0 mid-CNT_B with DLY_A=4, DLY_B=8 -> all outputs 0 immediately (asynchronously); after CLR_N release with EN_SYNC=1, the sequence restarts from the beginning.
- Nominal, no macro, DLY_A=4, DLY_B=8: EN_SYNC rises before edge 0 -> BUSY=1 after edge 0, RSTN_A=1 after edge 4, RSTN_B=DONE=1 and BUSY=0 after edge 12, all stable thereafter.
- Minimum delays, DLY_A=1, DLY_B=1: RSTN_A rises after edge 1; RSTN_B and DONE rise after edge 2.
- Abort priority: EN_SYNC=0 sampled on edge 4, the same edge as the CNT_A match -> RSTN_A stays 0, state IDLE; EN_SYNC=1 again on edge 6 -> RSTN_A rises after edge 10.
- Macro on, ACK_B held 0 until edge 20: RSTN_B rises after edge 12; DONE=0 and BUSY=1 through edge 19; DONE=1 after edge 20. A second run with ACK_B=1 on edge 12 -> DONE after edge 13.
- Abort from DONE: EN_SYNC dropped on edge 30 -> RSTN_A=RSTN_B=DONE=0 after edge 30; ACK_B=1 in IDLE has no effect.

Source files
------------

// File: rtl/aibcr3_rstseq_fsm_if.sv
// Handshake bundle between the reset sequencer and its surroundings:
// synchronized enable and domain-B acknowledge in, reset/status flags out.
interface aibcr3_rstseq_fsm_if;
    logic EN_SYNC;
    logic ACK_B;
    logic RSTN_A;
    logic RSTN_B;
    logic DONE;
    logic BUSY;

    modport master (output EN_SYNC, output ACK_B,
                    input  RSTN_A, input RSTN_B, input DONE, input BUSY);
    modport slave  (input  EN_SYNC, input ACK_B,
                    output RSTN_A, output RSTN_B, output DONE, output BUSY);
endinterface

// File: rtl/aibcr3_rstseq_fsm.sv
// Reset release sequencer: releases domain A, then domain B, after programmable delays.
// Define AIBCR3_RSTSEQ_ACK_EN to hold DONE until domain B acknowledges with ACK_B.
module aibcr3_rstseq_fsm #(
    parameter int CNT_W = 8,
    parameter int DLY_A = 4,
    parameter int DLY_B = 8
) (
    input logic                   CK,
    input logic                   CLR_N,
    aibcr3_rstseq_fsm_if.slave    bus
);
    localparam longint MAX_DLY = (longint'(1) << CNT_W) - 1;

    generate
        if (DLY_A < 1 || longint'(DLY_A) > MAX_DLY) begin : g_bad_dly_a
            $fatal(1, "aibcr3_rstseq_fsm: DLY_A out of range");
        end
        if (DLY_B < 1 || longint'(DLY_B) > MAX_DLY) begin : g_bad_dly_b
            $fatal(1, "aibcr3_rstseq_fsm: DLY_B out of range");
        end
    endgenerate

    localparam logic [CNT_W-1:0] W_DLY_A = CNT_W'(DLY_A);
    localparam logic [CNT_W-1:0] W_DLY_B = CNT_W'(DLY_B);
    localparam logic [CNT_W-1:0] W_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_A,
        S_CNT_B,
`ifdef AIBCR3_RSTSEQ_ACK_EN
        S_WAIT_ACK,
`endif
        S_DONE
    } state_t;

    state_t             r_state, w_nxt_state;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic               r_rstn_a, w_nxt_rstn_a;
    logic               r_rstn_b, w_nxt_rstn_b;
    logic               r_done, w_nxt_done;
    logic               r_busy, w_nxt_busy;

    always_ff @(posedge CK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rstn_a <= 1'b0;
            r_rstn_b <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_rstn_a <= w_nxt_rstn_a;
            r_rstn_b <= w_nxt_rstn_b;
            r_done   <= w_nxt_done;
            r_busy   <= w_nxt_busy;
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_rstn_a = r_rstn_a;
        w_nxt_rstn_b = r_rstn_b;
        w_nxt_done   = r_done;
        w_nxt_busy   = r_busy;

        // Enable loss outranks every other transition, including a counter match.
        if (r_state != S_IDLE && !bus.EN_SYNC) begin
            w_nxt_state  = S_IDLE;
            w_nxt_cnt    = '0;
            w_nxt_rstn_a = 1'b0;
            w_nxt_rstn_b = 1'b0;
            w_nxt_done   = 1'b0;
            w_nxt_busy   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.EN_SYNC) begin
                        w_nxt_state = S_CNT_A;
                        w_nxt_cnt   = W_ONE;
                        w_nxt_busy  = 1'b1;
                    end
                end
                S_CNT_A: begin
                    if (r_cnt == W_DLY_A) begin
                        w_nxt_state  = S_CNT_B;
                        w_nxt_cnt    = W_ONE;
                        w_nxt_rstn_a = 1'b1;
                    end else begin
                        w_nxt_cnt = r_cnt + W_ONE;
                    end
                end
                S_CNT_B: begin
                    if (r_cnt == W_DLY_B) begin
                        w_nxt_rstn_b = 1'b1;
`ifdef AIBCR3_RSTSEQ_ACK_EN
                        w_nxt_state  = S_WAIT_ACK;
`else
                        w_nxt_state  = S_DONE;
                        w_nxt_done   = 1'b1;
                        w_nxt_busy   = 1'b0;
`endif
                    end else begin
                        w_nxt_cnt = r_cnt + W_ONE;
                    end
                end
`ifdef AIBCR3_RSTSEQ_ACK_EN
                S_WAIT_ACK: begin
                    if (bus.ACK_B) begin
                        w_nxt_state = S_DONE;
                        w_nxt_done  = 1'b1;
                        w_nxt_busy  = 1'b0;
                    end
                end
`endif
                S_DONE: begin
                end
                default: begin
                    w_nxt_state  = S_IDLE;
                    w_nxt_cnt    = '0;
                    w_nxt_rstn_a = 1'b0;
                    w_nxt_rstn_b = 1'b0;
                    w_nxt_done   = 1'b0;
                    w_nxt_busy   = 1'b0;
                end
            endcase
        end
    end

    assign bus.RSTN_A = r_rstn_a;
    assign bus.RSTN_B = r_rstn_b;
    assign bus.DONE   = r_done;
    assign bus.BUSY   = r_busy;
endmodule

// File: tb/tb_aibcr3_rstseq_fsm.sv
// Bench for aibcr3_rstseq_fsm: table vectors, corner sequences and random stimulus
// against an edge-count reference model, on a (4,8) and a (1,1) instance.
module tb_aibcr3_rstseq_fsm;
`ifdef AIBCR3_RSTSEQ_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic CK = 1'b0;
    logic clr_n = 1'b0;
    logic en = 1'b0;
    logic ack = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 CK = ~CK;

    aibcr3_rstseq_fsm_if u_if0 ();
    aibcr3_rstseq_fsm_if u_if1 ();
    assign u_if0.EN_SYNC = en;
    assign u_if0.ACK_B   = ack;
    assign u_if1.EN_SYNC = en;
    assign u_if1.ACK_B   = ack;

    aibcr3_rstseq_fsm #(.CNT_W(8), .DLY_A(4), .DLY_B(8)) u_dut0 (
        .CK(CK), .CLR_N(clr_n), .bus(u_if0.slave));
    aibcr3_rstseq_fsm #(.CNT_W(8), .DLY_A(1), .DLY_B(1)) u_dut1 (
        .CK(CK), .CLR_N(clr_n), .bus(u_if1.slave));

    // Model: n = edges since enable was first accepted (0 = idle); k = ack seen after B release.
    int n0 = 0, n1 = 0;
    bit k0 = 1'b0, k1 = 1'b0;

    function automatic int nxt_n(input int n, input logic e);
        if (n == 0) return e ? 1 : 0;
        if (!e) return 0;
        return (n < 60000) ? n + 1 : n;
    endfunction

    function automatic bit nxt_k(input int n, input bit k, input logic e, input logic a,
                                 input int da, input int db);
        if (n == 0 || !e) return 1'b0;
        if (ACK_EN && a && (n + 1) > da + db + 1) return 1'b1;
        return k;
    endfunction

    always @(posedge CK or negedge clr_n) begin
        if (!clr_n) begin
            n0 <= 0; n1 <= 0; k0 <= 1'b0; k1 <= 1'b0;
        end else begin
            n0 <= nxt_n(n0, en);
            n1 <= nxt_n(n1, en);
            k0 <= nxt_k(n0, k0, en, ack, 4, 8);
            k1 <= nxt_k(n1, k1, en, ack, 1, 1);
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        logic d0, d1;
        d0 = ACK_EN ? k0 : (n0 > 12);
        d1 = ACK_EN ? k1 : (n1 > 2);
        chk("m0.rstn_a", u_if0.RSTN_A, n0 > 4);
        chk("m0.rstn_b", u_if0.RSTN_B, n0 > 12);
        chk("m0.done",   u_if0.DONE,   d0);
        chk("m0.busy",   u_if0.BUSY,   (n0 > 0) && !d0);
        chk("m1.rstn_a", u_if1.RSTN_A, n1 > 1);
        chk("m1.rstn_b", u_if1.RSTN_B, n1 > 2);
        chk("m1.done",   u_if1.DONE,   d1);
        chk("m1.busy",   u_if1.BUSY,   (n1 > 0) && !d1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rstn_a0"}, u_if0.RSTN_A, 1'b0);
        chk({tag, ".rstn_b0"}, u_if0.RSTN_B, 1'b0);
        chk({tag, ".done0"},   u_if0.DONE,   1'b0);
        chk({tag, ".busy0"},   u_if0.BUSY,   1'b0);
        chk({tag, ".rstn_a1"}, u_if1.RSTN_A, 1'b0);
        chk({tag, ".done1"},   u_if1.DONE,   1'b0);
    endtask

    // Drive inputs for the coming edge, return half a cycle after it.
    task automatic step(input logic e, input logic a);
        en = e;
        ack = a;
        @(negedge CK);
    endtask

    typedef struct {
        logic en, ack;
        logic rstn_a, rstn_b, done, busy;
    } vec_t;
    vec_t tbl[16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].en     = 1'b1;
            tbl[i].ack    = 1'b1;
            tbl[i].rstn_a = (i >= 4);
            tbl[i].rstn_b = (i >= 12);
            tbl[i].done   = ACK_EN ? (i >= 13) : (i >= 12);
            tbl[i].busy   = !tbl[i].done;
        end

        // Reset state
        repeat (3) @(negedge CK);
        chk_zero("reset");
        chk_model();
        clr_n = 1'b1;

        // Nominal sequence, edge i checked half a cycle after edge i
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].en, tbl[i].ack);
            chk($sformatf("tbl%0d.rstn_a", i), u_if0.RSTN_A, tbl[i].rstn_a);
            chk($sformatf("tbl%0d.rstn_b", i), u_if0.RSTN_B, tbl[i].rstn_b);
            chk($sformatf("tbl%0d.done", i),   u_if0.DONE,   tbl[i].done);
            chk($sformatf("tbl%0d.busy", i),   u_if0.BUSY,   tbl[i].busy);
            chk_model();
        end

        // Abort from DONE, then ACK_B in IDLE must do nothing
        step(1'b0, 1'b0);
        chk_zero("abort_done");
        step(1'b0, 1'b1);
        chk_zero("ack_idle");
        chk_model();

        // Abort on the same edge as the CNT_A match, restart at edge 6
        for (int e = 0; e <= 10; e++) begin
            step(!(e == 4 || e == 5), 1'b0);
            chk_model();
            if (e == 4) begin
                chk("abort_prio.rstn_a", u_if0.RSTN_A, 1'b0);
                chk("abort_prio.busy",   u_if0.BUSY,   1'b0);
            end
            if (e == 9)  chk("restart.rstn_a_e9",  u_if0.RSTN_A, 1'b0);
            if (e == 10) chk("restart.rstn_a_e10", u_if0.RSTN_A, 1'b1);
        end

        // ACK_B held low until edge 20
        step(1'b0, 1'b0);
        for (int e = 0; e <= 21; e++) begin
            step(1'b1, e >= 20);
            chk_model();
            if (e == 11) chk("ack.rstn_b_e11", u_if0.RSTN_B, 1'b0);
            if (e == 12) chk("ack.rstn_b_e12", u_if0.RSTN_B, 1'b1);
            if (e == 19) begin
                chk("ack.done_e19", u_if0.DONE, !ACK_EN);
                chk("ack.busy_e19", u_if0.BUSY, ACK_EN);
            end
            if (e == 20) chk("ack.done_e20", u_if0.DONE, 1'b1);
        end

        // Async clear in CNT_B, then restart from scratch
        step(1'b0, 1'b0);
        for (int e = 0; e <= 6; e++) step(1'b1, 1'b0);
        chk("pre_clr.rstn_a", u_if0.RSTN_A, 1'b1);
        #2 clr_n = 1'b0;
        #1 chk_zero("async_clr");
        @(negedge CK);
        clr_n = 1'b1;
        for (int e = 0; e <= 13; e++) begin
            step(1'b1, 1'b1);
            chk_model();
            if (e == 3) chk("clr_restart.rstn_a_e3", u_if0.RSTN_A, 1'b0);
            if (e == 4) chk("clr_restart.rstn_a_e4", u_if0.RSTN_A, 1'b1);
        end

        // Random stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                #2 clr_n = 1'b0;
                #1 chk_zero("rand_clr");
                @(negedge CK);
                clr_n = 1'b1;
            end
            step(($urandom_range(0, 15) != 0), $urandom_range(0, 1) == 1);
            chk_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
